// File: rtl/hazard_stall_ctrl.sv
// Central stall/bubble/flush sequencer for the 5-stage pipe: load-use detection, HI/LO MDU
// scheduling and data-memory wait handling. Define STALL_PERF_CNT_EN for per-hazard stall counters.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 33,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        cpu_clk_50M,
    input  logic        rst,
    input  logic        id_rreg1,
    input  logic        id_rreg2,
    input  logic [4:0]  id_ra1,
    input  logic [4:0]  id_ra2,
    input  logic        exe_wreg,
    input  logic        exe_mreg,
    input  logic [4:0]  exe_wa,
    input  logic        id_mdu_start,
    input  logic        id_mdu_div,
    input  logic        id_hilo_rd,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        excp_flush,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_exe_stall,
    output logic        id_exe_bubble,
    output logic        exe_mem_stall,
    output logic        mem_wb_bubble,
    output logic        flush,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic        mem_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] lu_stall_cnt,
    output logic [31:0] mdu_stall_cnt,
    output logic [31:0] mem_stall_cnt
`endif
);

    localparam int MDU_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int MDU_CW  = (MDU_MAX > 1) ? $clog2(MDU_MAX) : 1;
    localparam logic [MDU_CW-1:0] MULT_LOAD = MDU_CW'(MULT_CYCLES - 1);
    localparam logic [MDU_CW-1:0] DIV_LOAD  = MDU_CW'(DIV_CYCLES - 1);
    localparam logic [7:0]        WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic {
        MDU_RUN,
        MDU_BUSY
    } mdu_state_e;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_ERR
    } mem_state_e;

    mdu_state_e        mdu_state_q, mdu_state_d;
    logic [MDU_CW-1:0] mdu_cnt_q, mdu_cnt_d;
    mem_state_e        mem_state_q, mem_state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;

    logic       lu;
    logic       mdu_is_busy;
    logic       mdu_last;
    logic       mdu_haz;
    logic       mw;
    logic       mdu_issue;
    logic [7:0] wait_inc;

    // Hazard terms, before priority is applied.
    assign lu = exe_mreg && exe_wreg && (exe_wa != 5'd0)
             && ((id_rreg1 && (id_ra1 == exe_wa)) || (id_rreg2 && (id_ra2 == exe_wa)));
    assign mdu_is_busy = (mdu_state_q == MDU_BUSY);
    assign mdu_last    = (mdu_cnt_q == '0);
    assign mdu_haz     = mdu_is_busy && (id_hilo_rd || id_mdu_start);
    assign mw          = mem_req && !mem_ack && (mem_state_q != MEM_ERR);
    assign wait_inc    = wait_cnt_q + 8'd1;

    // A mult/div only leaves ID when nothing holds or flushes it; BUSY is handled by mdu_haz.
    assign mdu_issue = (mdu_state_q == MDU_RUN) && id_mdu_start && !excp_flush && !lu && !mw;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        mdu_state_d = mdu_state_q;
        mdu_cnt_d   = mdu_cnt_q;
        if (excp_flush) begin
            mdu_state_d = MDU_RUN;
            mdu_cnt_d   = '0;
        end else begin
            case (mdu_state_q)
                MDU_RUN: begin
                    if (mdu_issue) begin
                        mdu_state_d = MDU_BUSY;
                        mdu_cnt_d   = id_mdu_div ? DIV_LOAD : MULT_LOAD;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_last) begin
                        mdu_state_d = MDU_RUN;
                    end else begin
                        mdu_cnt_d = mdu_cnt_q - 1'b1;
                    end
                end
                default: begin
                    mdu_state_d = MDU_RUN;
                    mdu_cnt_d   = '0;
                end
            endcase
        end
    end

    // The first stalled cycle is spent in IDLE, so WAIT gives up after MEM_TIMEOUT-1 more.
    always_comb begin
        mem_state_d = mem_state_q;
        wait_cnt_d  = wait_cnt_q;
        case (mem_state_q)
            MEM_IDLE: begin
                if (!excp_flush && mw) begin
                    mem_state_d = (MEM_TIMEOUT == 1) ? MEM_ERR : MEM_WAIT;
                    wait_cnt_d  = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (excp_flush || !mw) begin
                    mem_state_d = MEM_IDLE;
                    wait_cnt_d  = 8'd0;
                end else if (wait_inc == WAIT_LAST) begin
                    mem_state_d = MEM_ERR;
                    wait_cnt_d  = wait_inc;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            MEM_ERR: begin
                mem_state_d = MEM_ERR;
            end
            default: begin
                mem_state_d = MEM_IDLE;
                wait_cnt_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        // NOTE: non-blocking so every flop samples the pre-edge values of the others.
        if (rst) begin
            mdu_state_q <= MDU_RUN;
            mdu_cnt_q   <= '0;
            mem_state_q <= MEM_IDLE;
            wait_cnt_q  <= 8'd0;
        end else begin
            mdu_state_q <= mdu_state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            mem_state_q <= mem_state_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Priority: flush > memory wait > (MDU hazard | load-use); everything is quiet under reset.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_exe_stall  = 1'b0;
        id_exe_bubble = 1'b0;
        exe_mem_stall = 1'b0;
        mem_wb_bubble = 1'b0;
        flush         = 1'b0;
        mdu_busy      = 1'b0;
        mdu_done      = 1'b0;
        mem_timeout   = 1'b0;
        if (!rst) begin
            flush       = excp_flush;
            mdu_busy    = mdu_is_busy;
            mdu_done    = mdu_is_busy && mdu_last && !excp_flush;
            mem_timeout = (mem_state_q == MEM_ERR);
            if (!excp_flush) begin
                if (mw) begin
                    pc_stall      = 1'b1;
                    if_id_stall   = 1'b1;
                    id_exe_stall  = 1'b1;
                    exe_mem_stall = 1'b1;
                    mem_wb_bubble = 1'b1;
                end else if (lu || mdu_haz) begin
                    pc_stall      = 1'b1;
                    if_id_stall   = 1'b1;
                    id_exe_bubble = 1'b1;
                end
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] lu_cnt_q, lu_cnt_d;
    logic [31:0] mdu_cnt_perf_q, mdu_cnt_perf_d;
    logic [31:0] mem_cnt_q, mem_cnt_d;
    logic        lu_ev, mdu_ev, mem_ev;

    // Lu and MDU hazards can stall the same cycle; each is credited.
    assign lu_ev  = !excp_flush && !mw && lu;
    assign mdu_ev = !excp_flush && !mw && mdu_haz;
    assign mem_ev = !excp_flush && mw;

    always_comb begin
        lu_cnt_d       = lu_cnt_q + 32'(lu_ev);
        mdu_cnt_perf_d = mdu_cnt_perf_q + 32'(mdu_ev);
        mem_cnt_d      = mem_cnt_q + 32'(mem_ev);
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (rst) begin
            lu_cnt_q       <= 32'd0;
            mdu_cnt_perf_q <= 32'd0;
            mem_cnt_q      <= 32'd0;
        end else begin
            lu_cnt_q       <= lu_cnt_d;
            mdu_cnt_perf_q <= mdu_cnt_perf_d;
            mem_cnt_q      <= mem_cnt_d;
        end
    end

    assign lu_stall_cnt  = rst ? 32'd0 : lu_cnt_q;
    assign mdu_stall_cnt = rst ? 32'd0 : mdu_cnt_perf_q;
    assign mem_stall_cnt = rst ? 32'd0 : mem_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: load-use vector table, directed MDU/memory/flush/reset
// sequences, and randomized traffic against a cycle-count reference model.
module tb_hazard_stall_ctrl;

    localparam int MULT_CYCLES = 4;
    localparam int DIV_CYCLES  = 33;
    localparam int MEM_TIMEOUT = 255;

    logic       cpu_clk_50M = 1'b0;
    logic       rst = 1'b0;
    logic       id_rreg1, id_rreg2;
    logic [4:0] id_ra1, id_ra2;
    logic       exe_wreg, exe_mreg;
    logic [4:0] exe_wa;
    logic       id_mdu_start, id_mdu_div, id_hilo_rd;
    logic       mem_req, mem_ack, excp_flush;
    logic       pc_stall, if_id_stall, id_exe_stall, id_exe_bubble, exe_mem_stall;
    logic       mem_wb_bubble, flush, mdu_busy, mdu_done, mem_timeout;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] lu_stall_cnt, mdu_stall_cnt, mem_stall_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    hazard_stall_ctrl #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .cpu_clk_50M  (cpu_clk_50M),
        .rst          (rst),
        .id_rreg1     (id_rreg1),
        .id_rreg2     (id_rreg2),
        .id_ra1       (id_ra1),
        .id_ra2       (id_ra2),
        .exe_wreg     (exe_wreg),
        .exe_mreg     (exe_mreg),
        .exe_wa       (exe_wa),
        .id_mdu_start (id_mdu_start),
        .id_mdu_div   (id_mdu_div),
        .id_hilo_rd   (id_hilo_rd),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .excp_flush   (excp_flush),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .id_exe_stall (id_exe_stall),
        .id_exe_bubble(id_exe_bubble),
        .exe_mem_stall(exe_mem_stall),
        .mem_wb_bubble(mem_wb_bubble),
        .flush        (flush),
        .mdu_busy     (mdu_busy),
        .mdu_done     (mdu_done),
        .mem_timeout  (mem_timeout)
`ifdef STALL_PERF_CNT_EN
        ,
        .lu_stall_cnt (lu_stall_cnt),
        .mdu_stall_cnt(mdu_stall_cnt),
        .mem_stall_cnt(mem_stall_cnt)
`endif
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    logic [9:0] outs;
    assign outs = {pc_stall, if_id_stall, id_exe_stall, id_exe_bubble, exe_mem_stall,
                   mem_wb_bubble, flush, mdu_busy, mdu_done, mem_timeout};

    typedef struct {
        logic       mreg;
        logic       wreg;
        logic [4:0] wa;
        logic       r1;
        logic [4:0] a1;
        logic       r2;
        logic [4:0] a2;
        logic       exp_stall;
    } lu_vec_t;

    lu_vec_t lu_tab [0:8];

    // Reference model state: remaining busy cycles, consecutive stalled memory cycles, error flag.
    int          m_mdu_left;
    int          m_mem_run;
    bit          m_err;
    bit          m_busy, m_lu, m_haz, m_mw, m_go, m_pend;
    logic [9:0]  m_exp;
    int unsigned m_lu_cnt, m_mdu_cnt, m_mem_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected output vector; pc/if_id stall share 'hold', the memory-wait outputs share 'mws'.
    function automatic logic [9:0] e(bit hold, bit mws, bit bub, bit fl, bit busy, bit done, bit to);
        return {hold, hold, mws, bub, mws, mws, fl, busy, done, to};
    endfunction

    task automatic next_cycle();
        @(negedge cpu_clk_50M);
    endtask

    task automatic chk(input string name, input logic [9:0] exp);
        #1;
        check(name, {22'd0, outs}, {22'd0, exp});
    endtask

    task automatic idle_inputs();
        id_rreg1 = 0; id_rreg2 = 0; id_ra1 = 0; id_ra2 = 0;
        exe_wreg = 0; exe_mreg = 0; exe_wa = 0;
        id_mdu_start = 0; id_mdu_div = 0; id_hilo_rd = 0;
        mem_req = 0; mem_ack = 0; excp_flush = 0;
    endtask

    task automatic drive_lu(input logic [4:0] wa);
        exe_mreg = 1; exe_wreg = 1; exe_wa = wa; id_rreg1 = 1; id_ra1 = wa;
    endtask

    // Reset with busy-looking inputs applied: outputs must stay low while rst is high.
    task automatic do_reset();
        next_cycle();
        idle_inputs();
        rst = 1; excp_flush = 1; mem_req = 1; id_hilo_rd = 1; id_mdu_start = 1;
        drive_lu(5'd3);
        chk("reset_outputs_low", 10'd0);
        next_cycle();
        idle_inputs();
        rst = 0;
        chk("post_reset_idle", 10'd0);
`ifdef STALL_PERF_CNT_EN
        check("post_reset_lu_cnt", lu_stall_cnt, 32'd0);
        check("post_reset_mdu_cnt", mdu_stall_cnt, 32'd0);
        check("post_reset_mem_cnt", mem_stall_cnt, 32'd0);
`endif
    endtask

    initial begin
        lu_tab[0] = '{1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 5'd5, 1'b1};
        lu_tab[1] = '{1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 5'd5, 1'b0};
        lu_tab[2] = '{1'b1, 1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 5'd0, 1'b0};
        lu_tab[3] = '{1'b1, 1'b1, 5'd7,  1'b1, 5'd7,  1'b0, 5'd0, 1'b1};
        lu_tab[4] = '{1'b1, 1'b1, 5'd7,  1'b0, 5'd7,  1'b0, 5'd7, 1'b0};
        lu_tab[5] = '{1'b0, 1'b1, 5'd7,  1'b1, 5'd7,  1'b1, 5'd7, 1'b0};
        lu_tab[6] = '{1'b1, 1'b0, 5'd7,  1'b1, 5'd7,  1'b1, 5'd7, 1'b0};
        lu_tab[7] = '{1'b1, 1'b1, 5'd9,  1'b1, 5'd3,  1'b1, 5'd9, 1'b1};
        lu_tab[8] = '{1'b1, 1'b1, 5'd31, 1'b1, 5'd31, 1'b0, 5'd2, 1'b1};

        idle_inputs();
        do_reset();

        // Load-use table, pipeline otherwise idle.
        for (int i = 0; i <= 8; i++) begin
            next_cycle();
            idle_inputs();
            exe_mreg = lu_tab[i].mreg; exe_wreg = lu_tab[i].wreg; exe_wa = lu_tab[i].wa;
            id_rreg1 = lu_tab[i].r1;   id_ra1 = lu_tab[i].a1;
            id_rreg2 = lu_tab[i].r2;   id_ra2 = lu_tab[i].a2;
            chk($sformatf("lu_vec%0d", i), e(lu_tab[i].exp_stall, 0, lu_tab[i].exp_stall, 0, 0, 0, 0));
        end

        // A mult/div stalled by load-use must not start.
        next_cycle(); idle_inputs(); id_mdu_start = 1; drive_lu(5'd4);
        chk("lu_blocks_mdu", e(1, 0, 1, 0, 0, 0, 0));
        next_cycle(); idle_inputs();
        chk("lu_blocked_no_busy", e(0, 0, 0, 0, 0, 0, 0));

        // Div followed by a held mfhi.
        next_cycle(); idle_inputs(); id_mdu_start = 1; id_mdu_div = 1;
        chk("div_issue", e(0, 0, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 34; c++) begin
            next_cycle(); idle_inputs(); id_hilo_rd = 1;
            if (c <= 33) chk($sformatf("div_mfhi_c%0d", c), e(1, 0, 1, 0, 1, c == 33, 0));
            else         chk("div_mfhi_release", e(0, 0, 0, 0, 0, 0, 0));
        end

        // Mult with independent instructions behind it.
        next_cycle(); idle_inputs(); id_mdu_start = 1;
        chk("mult_issue", e(0, 0, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 5; c++) begin
            next_cycle(); idle_inputs();
            chk($sformatf("mult_indep_c%0d", c), e(0, 0, 0, 0, c <= 4, c == 4, 0));
        end

        // Back-to-back mult: the second waits until the first has finished.
        next_cycle(); idle_inputs(); id_mdu_start = 1;
        chk("mult2_issue", e(0, 0, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 10; c++) begin
            next_cycle(); idle_inputs(); id_mdu_start = (c <= 5);
            if (c <= 4)       chk($sformatf("mult2_wait_c%0d", c), e(1, 0, 1, 0, 1, c == 4, 0));
            else if (c == 5)  chk("mult2_second_issue", e(0, 0, 0, 0, 0, 0, 0));
            else if (c <= 9)  chk($sformatf("mult2_run_c%0d", c), e(0, 0, 0, 0, 1, c == 9, 0));
            else              chk("mult2_after", e(0, 0, 0, 0, 0, 0, 0));
        end

        // Memory wait for three cycles, then ack.
        for (int c = 0; c <= 4; c++) begin
            next_cycle(); idle_inputs(); mem_req = (c <= 3); mem_ack = (c == 3);
            chk($sformatf("memwait_c%0d", c), e(c <= 2, c <= 2, 0, 0, 0, 0, 0));
        end
        next_cycle(); idle_inputs(); mem_req = 1; mem_ack = 1;
        chk("mem_same_cycle_ack", e(0, 0, 0, 0, 0, 0, 0));
        next_cycle(); idle_inputs(); mem_req = 1; drive_lu(5'd6);
        chk("mw_over_lu", e(1, 1, 0, 0, 0, 0, 0));
        next_cycle(); idle_inputs(); mem_req = 1; mem_ack = 1; drive_lu(5'd6);
        chk("lu_after_ack", e(1, 0, 1, 0, 0, 0, 0));

        // MDU keeps counting through a memory wait; hilo read is held, not bubbled.
        next_cycle(); idle_inputs(); id_mdu_start = 1;
        chk("mult_mw_issue", e(0, 0, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 4; c++) begin
            next_cycle(); idle_inputs(); mem_req = 1; mem_ack = (c == 4); id_hilo_rd = (c <= 3);
            if (c <= 3) chk($sformatf("mult_mw_c%0d", c), e(1, 1, 0, 0, 1, 0, 0));
            else        chk("mult_mw_done", e(0, 0, 0, 0, 1, 1, 0));
        end

        // Memory timeout: MEM_TIMEOUT stalled cycles, then sticky error with stalls released.
        for (int c = 0; c <= MEM_TIMEOUT; c++) begin
            next_cycle(); idle_inputs(); mem_req = 1;
            if (c < MEM_TIMEOUT) chk($sformatf("timeout_wait_c%0d", c), e(1, 1, 0, 0, 0, 0, 0));
            else                 chk("timeout_err", e(0, 0, 0, 0, 0, 0, 1));
        end
        next_cycle(); idle_inputs(); mem_req = 1; drive_lu(5'd8);
        chk("err_lu_still_works", e(1, 0, 1, 0, 0, 0, 1));
        next_cycle(); idle_inputs(); excp_flush = 1;
        chk("err_flush", e(0, 0, 0, 1, 0, 0, 1));
        next_cycle(); idle_inputs();
        chk("err_sticky_after_flush", e(0, 0, 0, 0, 0, 0, 1));
        do_reset();

        // Flush in the middle of a div.
        next_cycle(); idle_inputs(); id_mdu_start = 1; id_mdu_div = 1;
        chk("flushdiv_issue", e(0, 0, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 40; c++) begin
            next_cycle(); idle_inputs();
            if (c == 10) begin
                excp_flush = 1; id_hilo_rd = 1; mem_req = 1;
                chk("flushdiv_flush", e(0, 0, 0, 1, 1, 0, 0));
            end else begin
                chk($sformatf("flushdiv_c%0d", c), e(0, 0, 0, 0, c < 10, 0, 0));
            end
        end

        // Reset while the MDU is busy and memory is waiting.
        next_cycle(); idle_inputs(); id_mdu_start = 1; id_mdu_div = 1;
        chk("rstmid_issue", e(0, 0, 0, 0, 0, 0, 0));
        next_cycle(); idle_inputs(); mem_req = 1;
        chk("rstmid_mw0", e(1, 1, 0, 0, 1, 0, 0));
        next_cycle(); idle_inputs(); mem_req = 1;
        chk("rstmid_mw1", e(1, 1, 0, 0, 1, 0, 0));
        do_reset();
        next_cycle(); idle_inputs(); mem_req = 1;
        chk("rstmid_fresh_mw", e(1, 1, 0, 0, 0, 0, 0));
        next_cycle(); idle_inputs(); mem_req = 1; mem_ack = 1;
        chk("rstmid_fresh_ack", e(0, 0, 0, 0, 0, 0, 0));

        // Randomized traffic against the reference model.
        do_reset();
        m_mdu_left = 0; m_mem_run = 0; m_err = 0; m_pend = 0;
        m_lu_cnt = 0; m_mdu_cnt = 0; m_mem_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            next_cycle();
            rst          = ($urandom_range(0, 399) == 0);
            id_rreg1     = 1'($urandom_range(0, 1));
            id_rreg2     = 1'($urandom_range(0, 1));
            id_ra1       = 5'($urandom_range(0, 3));
            id_ra2       = 5'($urandom_range(0, 3));
            exe_wreg     = 1'($urandom_range(0, 1));
            exe_mreg     = 1'($urandom_range(0, 1));
            exe_wa       = 5'($urandom_range(0, 3));
            id_mdu_start = ($urandom_range(0, 5) == 0);
            id_mdu_div   = ($urandom_range(0, 2) == 0);
            id_hilo_rd   = ($urandom_range(0, 5) == 0);
            excp_flush   = ($urandom_range(0, 49) == 0);
            if (!m_pend) begin
                mem_req = ($urandom_range(0, 5) == 0);
                mem_ack = mem_req && ($urandom_range(0, 3) == 0);
            end else begin
                mem_req = 1;
                mem_ack = ($urandom_range(0, 2) == 0);
            end
            m_pend = mem_req && !mem_ack;
            #1;
            m_busy = (m_mdu_left > 0);
            m_lu   = exe_mreg && exe_wreg && exe_wa != 0
                  && ((id_rreg1 && id_ra1 == exe_wa) || (id_rreg2 && id_ra2 == exe_wa));
            m_haz  = m_busy && (id_hilo_rd || id_mdu_start);
            m_mw   = !m_err && mem_req && !mem_ack;
            m_go   = !rst && !excp_flush;
            m_exp  = e(m_go && (m_mw || m_lu || m_haz), m_go && m_mw, m_go && !m_mw && (m_lu || m_haz),
                       !rst && excp_flush, !rst && m_busy, m_go && m_mdu_left == 1, !rst && m_err);
            check($sformatf("rand_%0d", i), {22'd0, outs}, {22'd0, m_exp});
            if (rst) begin
                m_mdu_left = 0; m_mem_run = 0; m_err = 0;
                m_lu_cnt = 0; m_mdu_cnt = 0; m_mem_cnt = 0;
            end else begin
                if (m_go && !m_mw && m_lu)  m_lu_cnt++;
                if (m_go && !m_mw && m_haz) m_mdu_cnt++;
                if (m_go && m_mw)           m_mem_cnt++;
                if (excp_flush)                       m_mdu_left = 0;
                else if (m_busy)                      m_mdu_left--;
                else if (id_mdu_start && !m_lu && !m_mw)
                    m_mdu_left = id_mdu_div ? DIV_CYCLES : MULT_CYCLES;
                if (excp_flush || !m_mw) begin
                    m_mem_run = 0;
                end else begin
                    m_mem_run++;
                    if (m_mem_run == MEM_TIMEOUT) m_err = 1;
                end
            end
        end
        next_cycle(); idle_inputs(); rst = 0;
        #1;
`ifdef STALL_PERF_CNT_EN
        check("rand_lu_cnt", lu_stall_cnt, m_lu_cnt);
        check("rand_mdu_cnt", mdu_stall_cnt, m_mdu_cnt);
        check("rand_mem_cnt", mem_stall_cnt, m_mem_cnt);
`endif
        check("rand_final_timeout", {31'd0, mem_timeout}, {31'd0, m_err});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
